// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer:
// selection-mode encodings, packet-lock FSM states and a channel extractor
// for the flattened input bus. The extractor covers up to MAX_IN channels of
// up to MAX_WIDTH bits each.
package rr_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_WIDTH = 256;
  localparam int MAX_IN    = 32;
  localparam int MAX_BUS_W = MAX_WIDTH * MAX_IN;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Returns channel idx (width bits wide) from a flattened bus, zero-extended
  function automatic logic [MAX_WIDTH-1:0] get_channel(
    input logic [MAX_BUS_W-1:0] bus,
    input int                   idx,
    input int                   width
  );
    logic [MAX_BUS_W-1:0] shifted;
    logic [MAX_WIDTH-1:0] mask;
    shifted = bus >> (idx * width);
    if (width >= MAX_WIDTH) mask = '1;
    else                    mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    return shifted[MAX_WIDTH-1:0] & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: grants the first requester found when searching
// upward from ptr and wrapping modulo NUM_IN. Purely combinational; the
// pointer itself lives in the parent.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [SEL_W-1:0]  idx
);

  logic found;
  int   pos;

  // Walk the request vector from ptr, stopping at the first set bit
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      pos = (int'(ptr) + k) % NUM_IN;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = SEL_W'(pos);
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// Fixed-select or round-robin arbitration chosen by the mode input.
// Optional packet locking is compiled in with RR_MUX_PKT_LOCK_EN: a channel
// that starts a multi-beat packet (in_last=0) keeps the grant until its
// in_last=1 beat transfers.
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]        in_valid,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [NUM_IN-1:0]        in_last,
`endif
  output logic [NUM_IN-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_src
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic [NUM_IN-1:0] fix_gnt;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  gnt_idx;
  logic              can_load;
  logic              xfer;
  logic              ptr_adv;
  logic [WIDTH-1:0]  chan_data;

`ifdef RR_MUX_PKT_LOCK_EN
  arb_state_t        state_q, state_d;
  logic [SEL_W-1:0]  lock_q, lock_d;
`endif

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req (in_valid),
    .ptr (rr_ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // Fixed mode grants only the selected channel; out-of-range sel grants nothing
  always_comb begin
    fix_gnt = '0;
    if (int'(sel) < NUM_IN) fix_gnt[sel] = in_valid[sel];
  end

  // Pick the active grant source; a held packet lock overrides both modes
  always_comb begin
    grant   = fix_gnt;
    gnt_idx = sel;
    if (mode == MODE_RR) begin
      grant   = rr_gnt;
      gnt_idx = rr_idx;
    end
`ifdef RR_MUX_PKT_LOCK_EN
    if (state_q == LOCKED) begin
      grant          = '0;
      grant[lock_q]  = in_valid[lock_q];
      gnt_idx        = lock_q;
    end
`endif
  end

  // Handshake: accept a beat only when the output register is free or draining
  always_comb begin
    can_load  = !out_valid || out_ready;
    xfer      = can_load && (|grant);
    in_ready  = (rst || !can_load) ? '0 : grant;
    chan_data = WIDTH'(get_channel(MAX_BUS_W'(in_data), int'(gnt_idx), WIDTH));
`ifdef RR_MUX_PKT_LOCK_EN
    ptr_adv   = xfer && (mode == MODE_RR) && (state_q == ARB);
`else
    ptr_adv   = xfer && (mode == MODE_RR);
`endif
  end

  // Output register: capture on transfer, clear when consumed with nothing new
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= chan_data;
      out_src   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the channel that won
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (ptr_adv) begin
      if (gnt_idx == SEL_W'(NUM_IN - 1)) rr_ptr <= '0;
      else                               rr_ptr <= gnt_idx + SEL_W'(1);
    end
  end

`ifdef RR_MUX_PKT_LOCK_EN
  // Packet-lock state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // Lock on a non-final beat; release when the locked channel sends its last beat
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      ARB: begin
        if (xfer && !in_last[gnt_idx]) begin
          state_d = LOCKED;
          lock_d  = gnt_idx;
        end
      end
      LOCKED: begin
        if (xfer && in_last[lock_q]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed testbench for rr_stream_mux (NUM_IN=8, WIDTH=32). Channel i always
// carries data value i. The packet-lock section is compiled only when
// RR_MUX_PKT_LOCK_EN is defined.
module tb_rr_stream_mux;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 8;
  localparam int SEL_W  = 3;

  logic                    clk;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
`ifdef RR_MUX_PKT_LOCK_EN
  logic [NUM_IN-1:0]       in_last;
`endif
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_src;

  int num_vectors;
  int num_miscompares;

  rr_stream_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_vectors++;
    if (observed !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [SEL_W-1:0] s,
                               input logic [NUM_IN-1:0] v, input logic r);
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = r;
  endtask

  int exp_sparse [6] = '{2, 5, 6, 2, 5, 6};

  initial begin
    num_vectors     = 0;
    num_miscompares = 0;
    rst = 1'b1;
    for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = 32'(i);
`ifdef RR_MUX_PKT_LOCK_EN
    in_last = '1;
`endif
    applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);

    // Reset state: ready gated low even with requests pending
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_out_data", out_data, 32'h0);
    checkOutput("reset_out_src", 32'(out_src), 32'h0);

    // Fixed select sweep
    $display("[TB] fixed select sweep");
    for (int s = 0; s < NUM_IN; s++) begin
      applyStimulus(1'b0, 3'(s), 8'hFF, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("fixed_data_%0d", s), out_data, 32'(s));
      checkOutput($sformatf("fixed_src_%0d", s), 32'(out_src), 32'(s));
    end

    // Round-robin fairness, all requesting
    $display("[TB] round-robin fairness");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("rr_src_%0d", i), 32'(out_src), 32'(i % 8));
      checkOutput($sformatf("rr_valid_%0d", i), 32'(out_valid), 32'h1);
    end

    // Sparse requests with wrap
    $display("[TB] sparse round-robin");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 3'd0, 8'h64, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("sparse_src_%0d", i), 32'(out_src), 32'(exp_sparse[i]));
      checkOutput($sformatf("sparse_data_%0d", i), out_data, 32'(exp_sparse[i]));
    end

    // Async reset between edges with a beat held
    $display("[TB] async reset mid-stream");
    #2 rst = 1'b1;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'h0);
    checkOutput("async_out_data", out_data, 32'h0);
    checkOutput("async_in_ready", 32'(in_ready), 32'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("restart_src_%0d", i), 32'(out_src), 32'(i));
    end

    // Backpressure holding beat 3
    $display("[TB] backpressure");
    applyStimulus(1'b1, 3'd0, 8'hFF, 1'b0);
    #1;
    checkOutput("bp_in_ready_now", 32'(in_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_data_%0d", i), out_data, 32'h3);
      checkOutput($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'h1);
      checkOutput($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'h0);
    end
    applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'h10);
    @(negedge clk);
    checkOutput("bp_release_data", out_data, 32'h4);

    // Drain: fixed select on an idle channel empties the register
    applyStimulus(1'b0, 3'd3, 8'h00, 1'b1);
    #1;
    checkOutput("drain_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    checkOutput("drain_out_valid", 32'(out_valid), 32'h0);

`ifdef RR_MUX_PKT_LOCK_EN
    // Packet lock: park pointer at 1, then channel 1 sends a 3-beat packet
    $display("[TB] packet lock");
    applyStimulus(1'b1, 3'd0, 8'h01, 1'b1);
    @(negedge clk);
    checkOutput("lock_prep_src", 32'(out_src), 32'h0);
    in_last = 8'hFD;
    applyStimulus(1'b1, 3'd0, 8'h07, 1'b1);
    @(negedge clk);
    checkOutput("lock_beat0_src", 32'(out_src), 32'h1);
    applyStimulus(1'b0, 3'd0, 8'h07, 1'b1);
    @(negedge clk);
    checkOutput("lock_beat1_src", 32'(out_src), 32'h1);
    in_last = 8'hFF;
    applyStimulus(1'b1, 3'd0, 8'h07, 1'b1);
    @(negedge clk);
    checkOutput("lock_beat2_src", 32'(out_src), 32'h1);
    @(negedge clk);
    checkOutput("lock_after_src", 32'(out_src), 32'h2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
